// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_if_pkg
// Description : Shared types and helpers for the parametrised memory
//               interface (FSM state encoding, wait counter sizing,
//               range check and strobe width helper).
// Revision    : 1.0  initial release
// ============================================================================
package mem_if_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wait counter is wide enough for the largest supported wait-state count
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned MAX_WAIT_STATES = 15;

  // Number of byte lanes for a given data width
  function automatic int unsigned strb_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // True when a word address falls inside the implemented storage
  function automatic logic in_range(input int unsigned addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_if_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_if_array
// Description : DEPTH x DATA_W storage with synchronous byte-enabled write
//               and combinational read. Contents are not reset.
// Revision    : 1.0  initial release
// ============================================================================
module mem_if_array
  import mem_if_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int unsigned STRB_W = strb_w(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte-lane write; the caller only enables writes for in-range addresses
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wr_strb[b]) begin
          mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Asynchronous read, forced to zero outside the implemented words
  always_comb begin
    rd_data = '0;
    if (in_range(32'(rd_addr), DEPTH)) begin
      rd_data = mem_q[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/param_memory_interface.sv
`default_nettype none
// ============================================================================
// Module      : param_memory_interface
// Description : Word-addressed memory slave behind a req/ready handshake with
//               byte strobes, programmable wait states, registered read data
//               and an error response for out-of-range addresses.
// Revision    : 1.0  initial release
// ============================================================================
module param_memory_interface
  import mem_if_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  req_rnw_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  input  logic [DATA_W/8-1:0]   req_wstrb_i,
  output logic                  req_ready_o,
  output logic [DATA_W-1:0]     req_rdata_o,
  output logic                  req_err_o
);

  localparam int unsigned    STRB_W   = strb_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  // Reject unsupported parameterisations at elaboration
  generate
    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
      $error("param_memory_interface: DATA_W must be a non-zero multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $error("param_memory_interface: DEPTH must be in 1..2**ADDR_W");
    end
    if (WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait
      $error("param_memory_interface: WAIT_STATES must be in 0..15");
    end
  endgenerate

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rnw_q, rnw_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   cur_addr;
  logic                cur_rnw;
  logic [DATA_W-1:0]   cur_wdata;
  logic [STRB_W-1:0]   cur_wstrb;
  logic                cur_in_range;
  logic                mem_wr_en;
  logic [DATA_W-1:0]   mem_rdata;

  // Zero wait states commit on the accepting edge, before the capture
  // registers are loaded, so the live request is used while in IDLE
  always_comb begin
    cur_addr     = (state_q == IDLE) ? req_addr_i  : addr_q;
    cur_rnw      = (state_q == IDLE) ? req_rnw_i   : rnw_q;
    cur_wdata    = (state_q == IDLE) ? req_wdata_i : wdata_q;
    cur_wstrb    = (state_q == IDLE) ? req_wstrb_i : wstrb_q;
    cur_in_range = in_range(32'(cur_addr), DEPTH);
  end

  // Next-state, capture and commit logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rnw_d     = rnw_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_wr_en = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d  = req_addr_i;
          rnw_d   = req_rnw_i;
          wdata_d = req_wdata_i;
          wstrb_d = req_wstrb_i;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Commit happens on the edge that enters RESP
    if (state_d == RESP && state_q != RESP) begin
      err_d = ~cur_in_range;
      if (!cur_in_range) begin
        rdata_d = '0;
      end else if (cur_rnw) begin
        rdata_d = mem_rdata;
      end else begin
        mem_wr_en = 1'b1;
      end
    end
  end

  // State, capture and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rnw_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rnw_q   <= rnw_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  mem_if_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (cur_addr),
    .wr_data (cur_wdata),
    .wr_strb (cur_wstrb),
    .rd_addr (cur_addr),
    .rd_data (mem_rdata)
  );

  assign req_ready_o = (state_q == RESP);
  assign req_rdata_o = rdata_q;
  assign req_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_param_memory_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_memory_interface
// Description : Self-checking bench for param_memory_interface. Instance 0
//               has no wait states and 16 words; instance 1 has three wait
//               states and 12 words. A reference memory model predicts the
//               response of each transaction into a scoreboard queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_param_memory_interface;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int SW   = 4;
  localparam int WS0  = 0;
  localparam int WS1  = 3;
  localparam int DEP0 = 16;
  localparam int DEP1 = 12;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req   [2];
  logic          rnw   [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [SW-1:0] wstrb [2];
  logic          ready [2];
  logic [DW-1:0] rdata [2];
  logic          err   [2];

  logic [DW-1:0] mem_m   [2][16];
  logic [DW-1:0] last_rd [2];
  exp_t          sb [$];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  param_memory_interface #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP0), .WAIT_STATES(WS0)
  ) u_dut0 (
    .clk(clk), .reset(reset),
    .req_i(req[0]), .req_rnw_i(rnw[0]), .req_addr_i(addr[0]),
    .req_wdata_i(wdata[0]), .req_wstrb_i(wstrb[0]),
    .req_ready_o(ready[0]), .req_rdata_o(rdata[0]), .req_err_o(err[0])
  );

  param_memory_interface #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP1), .WAIT_STATES(WS1)
  ) u_dut1 (
    .clk(clk), .reset(reset),
    .req_i(req[1]), .req_rnw_i(rnw[1]), .req_addr_i(addr[1]),
    .req_wdata_i(wdata[1]), .req_wstrb_i(wstrb[1]),
    .req_ready_o(ready[1]), .req_rdata_o(rdata[1]), .req_err_o(err[1])
  );

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  function automatic int dep_of(input int d);
    return (d == 0) ? DEP0 : DEP1;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One handshake; request fields are scrambled while waiting to prove capture
  task automatic txn(input int d, input logic r, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input logic [SW-1:0] ws, input string tag);
    exp_t e;
    int   cyc;
    bit   seen;
    bit   inr;
    inr = (int'(a) < dep_of(d));
    if (!r && inr) begin
      for (int b = 0; b < SW; b++) begin
        if (ws[b]) mem_m[d][a][8*b +: 8] = wd[8*b +: 8];
      end
    end
    if (!inr) last_rd[d] = '0;
    else if (r) last_rd[d] = mem_m[d][a];
    e.rdata = last_rd[d];
    e.err   = ~inr;
    e.lat   = ws_of(d) + 1;
    sb.push_back(e);

    @(negedge clk);
    req[d] = 1'b1; rnw[d] = r; addr[d] = a; wdata[d] = wd; wstrb[d] = ws;
    seen = 1'b0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (ready[d] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      rnw[d] = ~r; addr[d] = a ^ 4'h6; wdata[d] = ~wd; wstrb[d] = ~ws;
    end
    req[d] = 1'b0;

    e = sb.pop_front();
    chk({tag, " ready"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(cyc), 32'(e.lat));
    chk({tag, " rdata"}, rdata[d], e.rdata);
    chk({tag, " err"}, 32'(err[d]), 32'(e.err));
    @(negedge clk);
    chk({tag, " pulse"}, 32'(ready[d]), 32'd0);
  endtask

  // Hold a read request high and verify acceptance spacing
  task automatic stream(input int d, input logic [AW-1:0] a, input int ncyc,
                        input int exp_pulses, input string tag);
    int   pulses;
    bit   dbl;
    logic prev;
    pulses = 0; dbl = 1'b0; prev = 1'b0;
    last_rd[d] = mem_m[d][a];
    @(negedge clk);
    req[d] = 1'b1; rnw[d] = 1'b1; addr[d] = a; wstrb[d] = '0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (ready[d] === 1'b1) begin
        pulses++;
        if (prev) dbl = 1'b1;
      end
      prev = (ready[d] === 1'b1);
    end
    req[d] = 1'b0;
    chk({tag, " pulses"}, 32'(pulses), 32'(exp_pulses));
    chk({tag, " back2back"}, 32'(dbl), 32'd0);
    chk({tag, " rdata"}, rdata[d], last_rd[d]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; rnw[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
      last_rd[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset%0d ready", d), 32'(ready[d]), 32'd0);
      chk($sformatf("reset%0d err", d), 32'(err[d]), 32'd0);
      chk($sformatf("reset%0d rdata", d), rdata[d], 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);

    // Zero wait states: basic write/read
    txn(0, 1'b0, 4'd3, 32'hDEADBEEF, 4'hF, "d0 wr3");
    txn(0, 1'b1, 4'd3, 32'h0,        4'h0, "d0 rd3");
    chk("d0 rd3 const", rdata[0], 32'hDEADBEEF);

    // Byte strobe merge
    txn(0, 1'b0, 4'd5, 32'h11223344, 4'hF,    "d0 wr5 full");
    txn(0, 1'b0, 4'd5, 32'hAABBCCDD, 4'b0101, "d0 wr5 strb");
    txn(0, 1'b1, 4'd5, 32'h0,        4'h0,    "d0 rd5");
    chk("d0 rd5 merged", rdata[0], 32'h11BB33DD);

    // Empty strobe write is a no-op; top word in range
    txn(0, 1'b0, 4'd3,  32'hCAFEBABE, 4'h0, "d0 wr3 nostrb");
    txn(0, 1'b1, 4'd3,  32'h0,        4'h0, "d0 rd3 again");
    txn(0, 1'b0, 4'd15, 32'h0F0FA5A5, 4'hF, "d0 wr15");
    txn(0, 1'b1, 4'd15, 32'h0,        4'h0, "d0 rd15");

    // Three wait states, 12 words: capture, latency and range errors
    txn(1, 1'b0, 4'd2,  32'h00000000, 4'hF, "d1 wr2 zero");
    txn(1, 1'b0, 4'd11, 32'h12345678, 4'hF, "d1 wr11");
    txn(1, 1'b1, 4'd11, 32'h0,        4'h0, "d1 rd11");
    txn(1, 1'b0, 4'd13, 32'hFFFFFFFF, 4'hF, "d1 wr13 oor");
    txn(1, 1'b1, 4'd13, 32'h0,        4'h0, "d1 rd13 oor");
    txn(1, 1'b1, 4'd11, 32'h0,        4'h0, "d1 rd11 again");

    // Reset in the middle of a write on instance 1
    @(negedge clk);
    req[1] = 1'b1; rnw[1] = 1'b0; addr[1] = 4'd2; wdata[1] = 32'hCAFEF00D; wstrb[1] = 4'hF;
    @(negedge clk);
    req[1] = 1'b0;
    chk("d1 pre-reset rdata", rdata[1], 32'h12345678);
    reset = 1'b0;
    #1;
    chk("d1 midrst ready", 32'(ready[1]), 32'd0);
    chk("d1 midrst err", 32'(err[1]), 32'd0);
    chk("d1 midrst rdata", rdata[1], 32'd0);
    chk("d0 midrst rdata", rdata[0], 32'd0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    txn(1, 1'b1, 4'd2, 32'h0, 4'h0, "d1 rd2 after abort");
    txn(0, 1'b1, 4'd3, 32'h0, 4'h0, "d0 rd3 after reset");

    // Continuous request: spacing of WAIT_STATES+2 cycles
    stream(0, 4'd3,  12, 6, "d0 stream");
    stream(1, 4'd11, 20, 4, "d1 stream");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
